// File: rtl/ddr2_wr_data_fifo_sync_if.sv
// Write-data FIFO bus: application write side plus controller read side.
// The master modport is the application/controller side; the slave modport is the FIFO.
interface ddr2_wr_data_fifo_sync_if #(
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic [MASK_WIDTH-1:0] app_mask_data;
    logic                  app_wdf_wren;
    logic                  ctrl_wdf_rden;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] wdf_data;
    logic [MASK_WIDTH-1:0] mask_data;
    logic                  wdf_valid;
    logic                  wr_df_full;
    logic                  wr_df_almost_full;
    logic                  wdf_empty;
    logic                  wdf_almost_empty;
    logic [ADDR_WIDTH:0]   wdf_count;
    logic                  wr_err;
    logic                  rd_err;

    modport master (
        output app_wdf_data, app_mask_data, app_wdf_wren, ctrl_wdf_rden, err_clr,
        input  wdf_data, mask_data, wdf_valid, wr_df_full, wr_df_almost_full,
               wdf_empty, wdf_almost_empty, wdf_count, wr_err, rd_err
    );

    modport slave (
        input  app_wdf_data, app_mask_data, app_wdf_wren, ctrl_wdf_rden, err_clr,
        output wdf_data, mask_data, wdf_valid, wr_df_full, wr_df_almost_full,
               wdf_empty, wdf_almost_empty, wdf_count, wr_err, rd_err
    );
endinterface

// File: rtl/ddr2_wr_data_fifo_sync.sv
// Single-clock DDR2 write-data FIFO (data + byte mask) with standard or
// first-word-fall-through read mode, occupancy count and sticky error flags.
module ddr2_wr_data_fifo_sync #(
    parameter int DATA_WIDTH          = 64,
    parameter int MASK_WIDTH          = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_FULL_OFFSET  = 4,
    parameter int ALMOST_EMPTY_OFFSET = 2,
    parameter int FWFT                = 0
) (
    input  logic clk0,
    input  logic rst_n,
    ddr2_wr_data_fifo_sync_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int WW    = DATA_WIDTH + MASK_WIDTH;

    localparam logic [CW-1:0] L_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] L_AF_LVL = CW'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CW-1:0] L_AE_LVL = CW'(ALMOST_EMPTY_OFFSET);

    logic [WW-1:0]         r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [WW-1:0]         r_word;
    logic                  r_valid;
    logic                  r_wr_err;
    logic                  r_rd_err;

    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_load;
    logic                  w_valid_nxt;
    logic                  w_empty;
    logic [CW-1:0]         w_mem_cnt;

    assign w_full   = (r_count == L_DEPTH);
    assign w_wr_acc = bus.app_wdf_wren && !w_full;

    // In FWFT mode the presented word has already left the RAM but is still
    // part of wdf_count, so the RAM occupancy is count minus the output slot.
    always_comb begin
        w_mem_cnt   = r_count;
        w_rd_acc    = bus.ctrl_wdf_rden && (r_count != '0);
        w_load      = w_rd_acc;
        w_valid_nxt = w_rd_acc;
        w_empty     = (r_count == '0);
        if (FWFT != 0) begin
            w_mem_cnt   = r_count - CW'(r_valid);
            w_rd_acc    = bus.ctrl_wdf_rden && r_valid;
            w_load      = (w_mem_cnt != '0) && (!r_valid || w_rd_acc);
            w_valid_nxt = w_load || (r_valid && !w_rd_acc);
            w_empty     = !r_valid;
        end
    end

    always_ff @(posedge clk0) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {bus.app_wdf_data, bus.app_mask_data};
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_load) begin
                r_word   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count  <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
            r_valid  <= w_valid_nxt;
            // A new error in the clearing cycle must survive the clear.
            r_wr_err <= (bus.app_wdf_wren && w_full) || (r_wr_err && !bus.err_clr);
            r_rd_err <= (bus.ctrl_wdf_rden && !w_rd_acc) || (r_rd_err && !bus.err_clr);
        end
    end

    assign bus.wdf_data          = r_word[WW-1:MASK_WIDTH];
    assign bus.mask_data         = r_word[MASK_WIDTH-1:0];
    assign bus.wdf_valid         = r_valid;
    assign bus.wr_df_full        = w_full;
    assign bus.wr_df_almost_full = (r_count >= L_AF_LVL);
    assign bus.wdf_empty         = w_empty;
    assign bus.wdf_almost_empty  = (r_count <= L_AE_LVL);
    assign bus.wdf_count         = r_count;
    assign bus.wr_err            = r_wr_err;
    assign bus.rd_err            = r_rd_err;
endmodule

// File: tb/tb_ddr2_wr_data_fifo_sync.sv
// Bench for ddr2_wr_data_fifo_sync: a standard-mode and an FWFT-mode instance
// share one stimulus stream and are compared against queue-based models.
module tb_ddr2_wr_data_fifo_sync;
    logic clk0 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk0 = ~clk0;

    ddr2_wr_data_fifo_sync_if #(.DATA_WIDTH(64), .MASK_WIDTH(8), .ADDR_WIDTH(4)) if_std ();
    ddr2_wr_data_fifo_sync_if #(.DATA_WIDTH(64), .MASK_WIDTH(8), .ADDR_WIDTH(4)) if_fwft ();

    ddr2_wr_data_fifo_sync #(.FWFT(0)) u_std  (.clk0(clk0), .rst_n(rst_n), .bus(if_std));
    ddr2_wr_data_fifo_sync #(.FWFT(1)) u_fwft (.clk0(clk0), .rst_n(rst_n), .bus(if_fwft));

    int checks   = 0;
    int failures = 0;

    // Models: q_std holds words not yet read; q_fw holds every word counted,
    // including the one currently presented.
    logic [71:0] q_std[$];
    logic [71:0] q_fw[$];
    logic [71:0] exp_d_std;
    logic        exp_v_std, exp_v_fw;
    logic        werr_std, rerr_std, werr_fw, rerr_fw;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_std.delete();
        q_fw.delete();
        exp_d_std = '0;
        exp_v_std = 1'b0;
        exp_v_fw  = 1'b0;
        werr_std  = 1'b0;
        rerr_std  = 1'b0;
        werr_fw   = 1'b0;
        rerr_fw   = 1'b0;
    endtask

    task automatic model_edge(input logic wr, input logic rd, input logic clr, input logic [71:0] w);
        bit full_s, empty_s, full_f, cons;
        int n_old;
        full_s  = (q_std.size() == 16);
        empty_s = (q_std.size() == 0);
        werr_std = (wr && full_s) || (werr_std && !clr);
        rerr_std = (rd && empty_s) || (rerr_std && !clr);
        if (rd && !empty_s) begin
            exp_d_std = q_std.pop_front();
            exp_v_std = 1'b1;
        end else begin
            exp_v_std = 1'b0;
        end
        if (wr && !full_s) q_std.push_back(w);

        full_f = (q_fw.size() == 16);
        cons   = rd && exp_v_fw;
        werr_fw = (wr && full_f) || (werr_fw && !clr);
        rerr_fw = (rd && !exp_v_fw) || (rerr_fw && !clr);
        if (cons) void'(q_fw.pop_front());
        n_old = q_fw.size();
        // A word becomes visible only once it was stored before this edge.
        exp_v_fw = (n_old > 0);
        if (wr && !full_f) q_fw.push_back(w);
    endtask

    task automatic check_all();
        chk("std_count",  80'(if_std.wdf_count), 80'(q_std.size()));
        chk("std_full",   80'(if_std.wr_df_full), 80'(q_std.size() == 16));
        chk("std_afull",  80'(if_std.wr_df_almost_full), 80'(q_std.size() >= 12));
        chk("std_empty",  80'(if_std.wdf_empty), 80'(q_std.size() == 0));
        chk("std_aempty", 80'(if_std.wdf_almost_empty), 80'(q_std.size() <= 2));
        chk("std_valid",  80'(if_std.wdf_valid), 80'(exp_v_std));
        chk("std_wr_err", 80'(if_std.wr_err), 80'(werr_std));
        chk("std_rd_err", 80'(if_std.rd_err), 80'(rerr_std));
        if (exp_v_std) chk("std_data", 80'({if_std.wdf_data, if_std.mask_data}), 80'(exp_d_std));
        chk("fw_count",  80'(if_fwft.wdf_count), 80'(q_fw.size()));
        chk("fw_full",   80'(if_fwft.wr_df_full), 80'(q_fw.size() == 16));
        chk("fw_afull",  80'(if_fwft.wr_df_almost_full), 80'(q_fw.size() >= 12));
        chk("fw_empty",  80'(if_fwft.wdf_empty), 80'(!exp_v_fw));
        chk("fw_aempty", 80'(if_fwft.wdf_almost_empty), 80'(q_fw.size() <= 2));
        chk("fw_valid",  80'(if_fwft.wdf_valid), 80'(exp_v_fw));
        chk("fw_wr_err", 80'(if_fwft.wr_err), 80'(werr_fw));
        chk("fw_rd_err", 80'(if_fwft.rd_err), 80'(rerr_fw));
        if (exp_v_fw) chk("fw_data", 80'({if_fwft.wdf_data, if_fwft.mask_data}), 80'(q_fw[0]));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_std_out"}, 80'({if_std.wdf_count, if_std.wdf_empty, if_std.wdf_almost_empty,
            if_std.wr_df_full, if_std.wr_df_almost_full, if_std.wdf_valid, if_std.wr_err, if_std.rd_err}),
            80'({5'd0, 1'b1, 1'b1, 5'b00000}));
        chk({tag, "_std_data"}, 80'({if_std.wdf_data, if_std.mask_data}), 80'(0));
        chk({tag, "_fw_out"}, 80'({if_fwft.wdf_count, if_fwft.wdf_empty, if_fwft.wdf_almost_empty,
            if_fwft.wr_df_full, if_fwft.wr_df_almost_full, if_fwft.wdf_valid, if_fwft.wr_err, if_fwft.rd_err}),
            80'({5'd0, 1'b1, 1'b1, 5'b00000}));
        chk({tag, "_fw_data"}, 80'({if_fwft.wdf_data, if_fwft.mask_data}), 80'(0));
    endtask

    task automatic drive(input logic wr, input logic rd, input logic clr, input logic [63:0] d, input logic [7:0] m);
        if_std.app_wdf_wren   = wr;  if_fwft.app_wdf_wren   = wr;
        if_std.ctrl_wdf_rden  = rd;  if_fwft.ctrl_wdf_rden  = rd;
        if_std.err_clr        = clr; if_fwft.err_clr        = clr;
        if_std.app_wdf_data   = d;   if_fwft.app_wdf_data   = d;
        if_std.app_mask_data  = m;   if_fwft.app_mask_data  = m;
    endtask

    task automatic step(input logic wr, input logic rd, input logic clr, input logic [63:0] d, input logic [7:0] m);
        drive(wr, rd, clr, d, m);
        @(posedge clk0);
        model_edge(wr, rd, clr, {d, m});
        #1;
        check_all();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        drive(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
        model_reset();
        repeat (2) @(posedge clk0);
        #1;
        check_reset_vals("reset");
        @(negedge clk0);
        rst_n = 1'b1;

        // Fill to full with data = index, then one dropped write.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 64'(i), 8'h00);
        step(1'b1, 1'b0, 1'b0, 64'hDEAD, 8'hFF);
        chk("overflow_wr_err", 80'(if_std.wr_err), 80'(1));
        chk("overflow_count", 80'(if_std.wdf_count), 80'(16));

        // Drain in order, then one read while empty.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
            chk("drain_order", 80'(if_std.wdf_data), 80'(i));
        end
        step(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
        chk("underflow_rd_err", 80'({if_std.rd_err, if_std.wdf_valid}), 80'(2'b10));
        step(1'b0, 1'b0, 1'b1, 64'd0, 8'd0);

        // Simultaneous traffic at count 5; 45 writes wrap the pointers twice.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, rnd64(), 8'($urandom()));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, rnd64(), 8'($urandom()));
        chk("simul_count", 80'(if_std.wdf_count), 80'(5));

        // Boundaries: both ops when full, then when empty.
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, rnd64(), 8'($urandom()));
        step(1'b1, 1'b1, 1'b0, rnd64(), 8'($urandom()));
        chk("full_both_count", 80'({if_std.wdf_count, if_std.wr_err}), 80'({5'd15, 1'b1}));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
        step(1'b1, 1'b1, 1'b0, rnd64(), 8'($urandom()));
        chk("empty_both_count", 80'({if_std.wdf_count, if_std.rd_err}), 80'({5'd1, 1'b1}));
        step(1'b0, 1'b0, 1'b1, 64'd0, 8'd0);
        chk("err_clr", 80'({if_std.wr_err, if_std.rd_err}), 80'(0));
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, rnd64(), 8'($urandom()));
        step(1'b1, 1'b0, 1'b1, rnd64(), 8'h00);
        chk("clr_vs_overflow", 80'(if_std.wr_err), 80'(1));

        // FWFT presentation latency and acknowledge.
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1, 64'd0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 64'hA5, 8'h00);
        chk("fwft_a5_not_yet", 80'(if_fwft.wdf_valid), 80'(0));
        step(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
        chk("fwft_a5_valid", 80'({if_fwft.wdf_valid, if_fwft.wdf_data}), 80'({1'b1, 64'hA5}));
        step(1'b1, 1'b0, 1'b0, 64'h5A5A, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
        chk("fwft_next", 80'({if_fwft.wdf_valid, if_fwft.wdf_data, if_fwft.mask_data}),
            80'({1'b1, 64'h5A5A, 8'h3C}));

        // Asynchronous reset with 9 words held.
        for (int i = 0; i < 32 && q_std.size() < 9; i++) step(1'b1, 1'b0, 1'b0, rnd64(), 8'($urandom()));
        chk("pre_reset_count", 80'(if_std.wdf_count), 80'(9));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals("async_reset");
        @(negedge clk0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h81);
        step(1'b0, 1'b1, 1'b0, 64'd0, 8'd0);
        chk("post_reset_data", 80'({if_std.wdf_valid, if_std.wdf_data, if_std.mask_data}),
            80'({1'b1, 64'h0123_4567_89AB_CDEF, 8'h81}));

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 rnd64(), 8'($urandom()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
